// File: rtl/neurram_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neurram_spi_pkg
//  Description : Shared definitions for the NeuRRAM SPI shift chain, used by
//                the target block and by the host shift controller: default
//                chain length and idle timeout, FSM state encoding, counter
//                widths, and a frame-length check helper.
//  Revision    : 1.0  initial release
// ============================================================================
package neurram_spi_pkg;

    localparam int unsigned c_SPI_LENGTH = 256;  // bits per lane
    localparam int unsigned c_TIMEOUT    = 64;   // idle clk cycles that end a frame
    localparam int unsigned c_LANES      = 2;    // serial lanes
    localparam int unsigned c_CNT_W      = 12;   // edge counter / bit_count width
    localparam int unsigned c_TMR_W      = 8;    // idle timer width (TIMEOUT <= 255)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } spi_state_t;

    // True when a frame of 'count' edges is not a whole number of chains.
    function automatic logic frame_len_bad(input logic [c_CNT_W-1:0] count,
                                           input int unsigned        len);
        return (({{(32-c_CNT_W){1'b0}}, count} % len) != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neurram_spi_target_if.sv
`default_nettype none
// ============================================================================
//  Module      : neurram_spi_target_if
//  Description : Serial bus between the host shift controller (master) and
//                the SPI shift-chain target (slave).
//                  spi_clk  : shift clock, host driven, asynchronous to clk
//                  spi_din  : one data bit per lane, LSB first
//                  spi_dout : return data, chain bit 0 of each lane
//  Revision    : 1.0  initial release
// ============================================================================
interface neurram_spi_target_if;
    import neurram_spi_pkg::*;

    logic               spi_clk;
    logic [c_LANES-1:0] spi_din;
    logic [c_LANES-1:0] spi_dout;

    modport master (output spi_clk, output spi_din, input  spi_dout);
    modport slave  (input  spi_clk, input  spi_din, output spi_dout);

endinterface
`default_nettype wire

// File: rtl/neurram_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : neurram_sync_edge
//  Description : Two-flop synchronizer with rising-edge detect. A third
//                registered copy of the synchronized signal is compared with
//                stage 2 to flag a rising edge for exactly one clk cycle.
//  Ports       : clk, rst (async, active-high)
//                i_async : asynchronous input
//                o_sync  : synchronized level (stage 2)
//                o_rise  : one-cycle rising-edge strobe
//  Revision    : 1.0  initial release
// ============================================================================
module neurram_sync_edge (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/neurram_spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : neurram_spi_target
//  Description : Two-lane SPI shift-chain target. Each lane is a SPI_LENGTH
//                bit chain shifted on spi_clk rising edges (MSB end takes new
//                data, bit 0 drives spi_dout). A frame ends after TIMEOUT idle
//                clk cycles; its contents, edge count and length error flag
//                are then published on cfg_out / bit_count / frame_err with a
//                one-cycle frame_done pulse. status_load (IDLE only) copies a
//                parallel readback word into the chain.
//  Ports       : clk, rst (async, active-high)
//                spi            : serial bus (slave modport)
//                i_status_in    : parallel readback, lane0 in low half
//                i_status_load  : one-cycle load request
//                o_cfg_out      : last completed frame, lane0 in low half
//                o_frame_done   : one-cycle pulse with fresh cfg_out
//                o_frame_err    : last frame length not a multiple of chain
//                o_bit_count    : edges in the last completed frame
//                o_busy         : FSM in SHIFT or UPDATE
//  Revision    : 1.0  initial release
// ============================================================================
module neurram_spi_target
    import neurram_spi_pkg::*;
#(
    parameter int unsigned SPI_LENGTH = c_SPI_LENGTH,
    parameter int unsigned TIMEOUT    = c_TIMEOUT
) (
    input  wire                            clk,
    input  wire                            rst,
    neurram_spi_target_if.slave            spi,
    input  wire  [c_LANES*SPI_LENGTH-1:0]  i_status_in,
    input  wire                            i_status_load,
    output logic [c_LANES*SPI_LENGTH-1:0]  o_cfg_out,
    output logic                           o_frame_done,
    output logic                           o_frame_err,
    output logic [c_CNT_W-1:0]             o_bit_count,
    output logic                           o_busy
);

    localparam int unsigned     c_W        = c_LANES * SPI_LENGTH;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic               w_edge;
    logic               w_sclk_sync_unused;
    logic [c_LANES-1:0] w_din;
    logic [c_LANES-1:0] w_din_rise_unused;

    neurram_sync_edge u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi.spi_clk),
        .o_sync  (w_sclk_sync_unused),
        .o_rise  (w_edge)
    );

    generate
        for (genvar g = 0; g < int'(c_LANES); g++) begin : g_din_sync
            neurram_sync_edge u_sync_din (
                .clk     (clk),
                .rst     (rst),
                .i_async (spi.spi_din[g]),
                .o_sync  (w_din[g]),
                .o_rise  (w_din_rise_unused[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_state_t         r_state,   w_state_nxt;
    logic [c_W-1:0]     r_chain,   w_chain_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [c_TMR_W-1:0] r_tmr,     w_tmr_nxt;
    logic               w_commit;
    logic [c_W-1:0]     w_shifted;
    logic [c_LANES-1:0] w_dout;

    // Per-lane shift image and serial return bit.
    always_comb begin
        w_shifted = '0;
        w_dout    = '0;
        for (int l = 0; l < int'(c_LANES); l++) begin
            w_shifted[l*SPI_LENGTH +: SPI_LENGTH] =
                {w_din[l], r_chain[l*SPI_LENGTH+1 +: SPI_LENGTH-1]};
            w_dout[l] = r_chain[l*SPI_LENGTH];
        end
    end

    // Next-state logic. Frame results are committed on the transition into
    // UPDATE so that frame_done is high during the UPDATE cycle together with
    // the new cfg_out/bit_count/frame_err. The chain cannot change between
    // that transition and UPDATE, so the published contents are the same.
    always_comb begin
        w_state_nxt = r_state;
        w_chain_nxt = r_chain;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = r_tmr;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A coincident load wins; the edge is discarded.
                if (i_status_load) begin
                    w_chain_nxt = i_status_in;
                end else if (w_edge) begin
                    w_chain_nxt = w_shifted;
                    w_cnt_nxt   = c_CNT_W'(1);
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_edge) begin
                    w_chain_nxt = w_shifted;
                    w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + c_CNT_W'(1);
                    w_tmr_nxt   = '0;
                end else if (r_tmr == c_TMR_LAST) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_UPDATE;
                end else begin
                    w_tmr_nxt   = r_tmr + c_TMR_W'(1);
                end
            end
            ST_UPDATE: begin
                if (w_edge) begin
                    w_chain_nxt = w_shifted;
                    w_cnt_nxt   = c_CNT_W'(1);
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_chain <= '0;
            r_cnt   <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_chain <= w_chain_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Published frame results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cfg_out    <= '0;
            o_bit_count  <= '0;
            o_frame_err  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= w_commit;
            if (w_commit) begin
                o_cfg_out   <= r_chain;
                o_bit_count <= r_cnt;
                o_frame_err <= frame_len_bad(r_cnt, SPI_LENGTH);
            end
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign spi.spi_dout = w_dout;

endmodule
`default_nettype wire

// File: tb/tb_neurram_spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neurram_spi_target
//  Description : Directed self-checking bench for neurram_spi_target with
//                SPI_LENGTH=256, TIMEOUT=64. The host side drives spi_clk on
//                clk falling edges; outputs are sampled on falling edges.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_neurram_spi_target;
    import neurram_spi_pkg::*;

    localparam int L = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic [2*L-1:0]   status_in;
    logic             status_load;
    logic [2*L-1:0]   cfg_out;
    logic             frame_done;
    logic             frame_err;
    logic [11:0]      bit_count;
    logic             busy;

    neurram_spi_target_if u_if ();

    neurram_spi_target #(
        .SPI_LENGTH (L),
        .TIMEOUT    (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi           (u_if.slave),
        .i_status_in   (status_in),
        .i_status_load (status_load),
        .o_cfg_out     (cfg_out),
        .o_frame_done  (frame_done),
        .o_frame_err   (frame_err),
        .o_bit_count   (bit_count),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_done = 0;
    logic [11:0] bc_log[$];

    // Record every frame_done pulse with the bit_count it published.
    always @(posedge clk) begin
        if (frame_done === 1'b1) begin
            n_done <= n_done + 1;
            bc_log.push_back(bit_count);
        end
    end

    task automatic chk(input string tag, input logic [2*L-1:0] obs, input logic [2*L-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One spi_clk period: low for 'lo' clk cycles with data set, then high for 'hi'.
    task automatic send_bit(input logic [1:0] d, input int lo, input int hi);
        u_if.spi_clk = 1'b0;
        u_if.spi_din = d;
        repeat (lo) @(negedge clk);
        u_if.spi_clk = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic wait_frames(input string tag, input int target);
        int k;
        k = 0;
        while (n_done < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk(tag, n_done, target);
    endtask

    initial begin
        logic [L-1:0]   p0;
        logic [15:0]    seq;
        logic [2*L-1:0] exp;
        logic           b0;
        logic           b1;
        int             k;

        rst          = 1'b1;
        status_in    = '0;
        status_load  = 1'b0;
        u_if.spi_clk = 1'b0;
        u_if.spi_din = 2'b00;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        chk("rst_cfg_out",    cfg_out,       '0);
        chk("rst_bit_count",  bit_count,     '0);
        chk("rst_frame_err",  frame_err,     '0);
        chk("rst_frame_done", frame_done,    '0);
        chk("rst_busy",       busy,          '0);
        chk("rst_spi_dout",   u_if.spi_dout, '0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 100; i++) send_bit(2'(i & 3), 2, 2);
        u_if.spi_clk = 1'b0;
        @(negedge clk);
        chk("midframe_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",      busy,      0);
        chk("midrst_bit_count", bit_count, 0);
        chk("midrst_chain_dout", u_if.spi_dout, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- 256 edges: lane0 0xA5.., lane1 ones ----------------
        p0 = {32{8'hA5}};
        for (int i = 0; i < L; i++) send_bit({1'b1, p0[i]}, 2, 2);
        wait_frames("a5_done_count", 1);
        chk("a5_bit_count", bit_count, 256);
        chk("a5_frame_err", frame_err, 0);
        chk("a5_cfg_out",   cfg_out,   {{L{1'b1}}, p0});
        chk("a5_spi_dout",  u_if.spi_dout, 2'b11);

        // ------- status_load coincident with an edge, then readback -------
        status_in    = {{L{1'b0}}, {(L-16){1'b0}}, 16'h1234};
        seq          = 16'h1234;
        u_if.spi_clk = 1'b0;
        u_if.spi_din = 2'b00;
        repeat (3) @(negedge clk);
        u_if.spi_clk = 1'b1;          // edge detected 2 cycles later
        @(negedge clk);
        @(negedge clk);
        status_load = 1'b1;           // same cycle as the detected edge
        @(negedge clk);
        status_load  = 1'b0;
        u_if.spi_clk = 1'b0;
        chk("load_edge_busy", busy, 0);
        chk("dout_seq0", u_if.spi_dout, {1'b0, seq[0]});
        for (int i = 1; i < 8; i++) begin
            send_bit(2'b00, 2, 3);
            chk($sformatf("dout_seq%0d", i), u_if.spi_dout, {1'b0, seq[i]});
        end
        // A load during SHIFT must be ignored.
        status_in   = '1;
        status_load = 1'b1;
        @(negedge clk);
        status_load = 1'b0;
        chk("shift_busy", busy, 1);
        for (int i = 7; i < L; i++) send_bit(2'b00, 2, 2);
        wait_frames("load_done_count", 2);
        chk("load_bit_count", bit_count, 256);
        chk("load_frame_err", frame_err, 0);
        chk("load_cfg_out",   cfg_out,   '0);

        // ---------------- 300-edge frame ----------------
        for (int i = 0; i < 300; i++) begin
            b0 = ((i % 3) == 0);
            b1 = ((i % 7) < 3);
            send_bit({b1, b0}, 2, 2);
        end
        exp = '0;
        for (int j = 0; j < L; j++) begin
            exp[j]     = (((44 + j) % 3) == 0);
            exp[L + j] = (((44 + j) % 7) < 3);
        end
        wait_frames("long_done_count", 3);
        chk("long_bit_count", bit_count, 300);
        chk("long_frame_err", frame_err, 1);
        chk("long_cfg_out",   cfg_out,   exp);

        // ------- 63 idle cycles between edges: no split; done latency -------
        for (int i = 0; i < 8; i++) send_bit(2'b01, 2, 2);
        send_bit(2'b10, 62, 2);       // rise-to-rise 64 clk
        for (int i = 0; i < 7; i++) send_bit(2'b11, 2, 2);
        // Last rise was 2 falling edges ago. Edge detected 1.5 clk after the
        // rise; 64 idle cycles; UPDATE next cycle -> seen 67 falling edges
        // after the rise, i.e. 65 from here.
        k = 0;
        while (frame_done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("gap63_done_latency", k, 65);
        chk("gap63_bit_count", bit_count, 16);
        chk("gap63_frame_err", frame_err, 1);
        chk("gap63_cfg_top", {cfg_out[2*L-1 -: 16], cfg_out[L-1 -: 16]}, {16'hFF00, 16'hFEFF});
        wait_frames("gap63_done_count", 4);

        // ------- 64 idle cycles: split, next edge lands in UPDATE -------
        for (int i = 0; i < 10; i++) send_bit(2'b00, 2, 2);
        send_bit(2'b01, 63, 2);       // rise-to-rise 65 clk
        for (int i = 0; i < 5; i++) send_bit(2'b00, 2, 2);
        wait_frames("gap64_done_count", 6);
        chk("gap64_first_bc",  (bc_log.size() > 4) ? bc_log[4] : 12'hFFF, 10);
        chk("gap64_second_bc", (bc_log.size() > 5) ? bc_log[5] : 12'hFFF, 6);
        chk("gap64_bit_count", bit_count, 6);
        chk("gap64_frame_err", frame_err, 1);
        chk("gap64_busy_end",  busy,      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
